pre_i_mode_pingpong: RTL and testbench
======================================

// Module: pre_i_mode_pingpong
// PURPOSE
//  Ping-pong mode buffer directly downstream of pre-intra mode decision. Captures the per-LCU
//  best-mode write stream (md_we/md_waddr/md_wdata, closed by finish) into one of two banks.
//  Serves the completed bank to the intra prediction stage while pre-intra fills the other bank.
//  Also checks the per-LCU mode count.
// PARAMETERS
//  AW        7   mode address width; bank depth is 2**AW entries
//  DW        6   mode word width
//  MODE_CNT  85  required writes per LCU: 64 8x8 + 16 16x16 + 4 32x32 + 1 64x64
// PORTS
//  clk          in   1   clock, all logic on posedge
//  rstn         in   1   reset; synchronous, active-low
//  md_we_i      in   1   mode write strobe from pre-intra
//  md_waddr_i   in   AW  mode write address
//  md_wdata_i   in   DW  mode value
//  md_finish_i  in   1   one-cycle pulse: LCU mode stream complete
//  wr_ready_o   out  1   write bank free; pre-intra enable is gated with this
//  rd_valid_o   out  1   a complete bank is available to the consumer
//  rd_ren_i     in   1   consumer read strobe
//  rd_addr_i    in   AW  consumer read address
//  rd_data_o    out  DW  read data, one cycle after rd_ren_i
//  rd_done_i    in   1   one-cycle pulse: consumer releases the current read bank
//  lcu_cnt_o    out  16  number of LCUs completed on the write side; wraps at 0xFFFF
//  err_o        out  3   sticky: [0] write/finish while !wr_ready, [1] done while !rd_valid,
//                        [2] write count != MODE_CNT at finish
// BEHAVIOUR
//  Reset (rstn==0 at posedge, any cycle, mid-LCU included):
//   - wsel, rsel, bank_full[1:0], wcnt, lcu_cnt_o, err_o, rd_data_o all go to 0.
//   - RAM contents are kept but are unreachable until refilled.
//   - wr_ready_o=1, rd_valid_o=0 in the first cycle after reset.
//  State: wsel = write bank, rsel = read bank, bank_full[b] per bank.
//   - wr_ready_o = ~bank_full[wsel]; rd_valid_o = bank_full[rsel]. Both are combinational from registers.
//  Write path:
//   - md_we_i & wr_ready_o: bank[wsel][md_waddr_i] <= md_wdata_i and wcnt++ (saturates at 2**8-1).
//   - md_we_i & ~wr_ready_o: write is dropped and err_o[0] is set.
//   - Writes to the same address overwrite; the count still increments.
//  Finish:
//   - md_finish_i & wr_ready_o: bank_full[wsel] <= 1, wsel toggles, wcnt <= 0, lcu_cnt_o++.
//   - At finish, err_o[2] is set if the count including a same-cycle write != MODE_CNT.
//   - md_we_i in the finish cycle is written to the closing bank and counted.
//   - md_finish_i & ~wr_ready_o: ignored and err_o[0] is set.
//  Read path:
//   - rd_ren_i: rd_data_o <= bank[rsel][rd_addr_i]; otherwise rd_data_o holds.
//   - Reads while !rd_valid_o return stale content and set no error.
//  Release:
//   - rd_done_i & rd_valid_o: bank_full[rsel] <= 0 and rsel toggles.
//   - rd_done_i & !rd_valid_o: ignored and err_o[1] is set.
//   - rd_ren_i in the done cycle still reads the old rsel.
//  Simultaneous finish + done:
//   - Always on different banks, so both apply in the same cycle.
//   - When both banks are full, wr_ready_o=0 until done.
//  Freed bank: wr_ready_o rises the cycle after done, and a write is legal that same cycle.
//  Ordering: the read side never sees a bank before its finish (write-to-read latency is 1 cycle after finish).
//  Width rules: lcu_cnt_o wraps modulo 2**16; wcnt is 8 bits wide.
// STRUCTURE
//  Shared package constants: MODE_AW=7, MODE_DW=6, MODE_CNT=85, LCU_CNT_W=16.
//  Sub-module pre_i_mode_bank: simple dual-port RAM, 2**AW x DW, synchronous write, registered read.
//   - Instantiated twice.
//   - rd_data_o is muxed from the two banks by rsel, registered at the read.
//  Top: bank_full/wsel/rsel control, wcnt checker, error flags.
// TESTING
//  1 Reset, then 85 writes (addr i, data i%35) and finish
//    -> rd_valid_o=1 next cycle, wr_ready_o=1, lcu_cnt_o=1, err_o=0; read addr 40 -> 5 next cycle.
//  2 Fill bank0 and bank1 without any done
//    -> wr_ready_o=0; a third write is dropped, err_o=3'b001, bank contents unchanged.
//  3 Both banks full, then done
//    -> rsel=1 and rd_valid_o=1 (bank1 data); wr_ready_o=1 the next cycle; new LCU written to bank0.
//  4 Finish on bank1 in the same cycle as done on bank0 -> both take effect, rd_valid_o stays 1, err_o=0.
//  5 Only 84 writes, then finish -> err_o[2]=1 and the bank still marked full.
//    done with rd_valid_o=0 -> err_o[1]=1.
//  6 rstn low for 1 cycle mid-LCU (40 writes done)
//    -> all flags 0, wr_ready_o=1, rd_valid_o=0, wcnt restarts; the next 85-write LCU gives no err.

Source files
------------

// File: rtl/pre_i_mode_pingpong_pkg.sv
// Shared constants and small helpers for the pre-intra mode ping-pong buffer.
package pre_i_mode_pingpong_pkg;

   localparam int MODE_AW   = 7;
   localparam int MODE_DW   = 6;
   localparam int MODE_CNT  = 85;
   localparam int LCU_CNT_W = 16;
   localparam int WCNT_W    = 8;

   // Bit positions inside the sticky error vector
   localparam int ERR_WR  = 0;
   localparam int ERR_RD  = 1;
   localparam int ERR_CNT = 2;

   typedef enum logic {
      BANK0 = 1'b0,
      BANK1 = 1'b1
   } bank_e;

   // Write counter increment that sticks at all-ones instead of wrapping
   function automatic logic [WCNT_W-1:0] satInc(input logic [WCNT_W-1:0] v);
      return (v == {WCNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pre_i_mode_pingpong_bank.sv
// One mode bank: simple dual-port RAM with synchronous write and registered read.
module pre_i_mode_bank
   import pre_i_mode_pingpong_pkg::*;
#(
   parameter int AW = MODE_AW,
   parameter int DW = MODE_DW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rdata_q;

   // Storage array is never cleared; stale content is harmless because the
   // control side only exposes a bank after it has been refilled
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read register updates only on a read strobe so the output holds otherwise
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pre_i_mode_pingpong.sv
// Ping-pong mode buffer between pre-intra mode decision and intra prediction.
module pre_i_mode_pingpong
   import pre_i_mode_pingpong_pkg::*;
#(
   parameter int AW       = MODE_AW,
   parameter int DW       = MODE_DW,
   parameter int MODE_CNT = pre_i_mode_pingpong_pkg::MODE_CNT
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 md_we_i,
   input  logic [AW-1:0]        md_waddr_i,
   input  logic [DW-1:0]        md_wdata_i,
   input  logic                 md_finish_i,
   output logic                 wr_ready_o,
   output logic                 rd_valid_o,
   input  logic                 rd_ren_i,
   input  logic [AW-1:0]        rd_addr_i,
   output logic [DW-1:0]        rd_data_o,
   input  logic                 rd_done_i,
   output logic [LCU_CNT_W-1:0] lcu_cnt_o,
   output logic [2:0]           err_o
);

   bank_e                wSel_q,     wSel_d;
   bank_e                rSel_q,     rSel_d;
   bank_e                rdSel_q,    rdSel_d;
   logic [1:0]           bankFull_q, bankFull_d;
   logic [WCNT_W-1:0]    wCnt_q,     wCnt_d;
   logic [LCU_CNT_W-1:0] lcuCnt_q,   lcuCnt_d;
   logic [2:0]           err_q,      err_d;

   logic              wrReady;
   logic              rdValid;
   logic              wrEn;
   logic              finishOk;
   logic              doneOk;
   logic [WCNT_W-1:0] wCntNext;
   logic [DW-1:0]     bankRdata [2];

   assign wrReady  = ~bankFull_q[wSel_q];
   assign rdValid  = bankFull_q[rSel_q];
   assign wrEn     = md_we_i & wrReady;
   assign finishOk = md_finish_i & wrReady;
   assign doneOk   = rd_done_i & rdValid;
   assign wCntNext = wrEn ? satInc(wCnt_q) : wCnt_q;

   // Both banks always see every read strobe; the captured bank select picks
   // which registered output is visible, so a read in the done cycle still
   // returns the bank that was being released
   for (genvar b = 0; b < 2; b++) begin : gBank
      pre_i_mode_bank #(
         .AW(AW),
         .DW(DW)
      ) uBank (
         .clk    (clk),
         .rstn   (rstn),
         .we_i   (wrEn && (wSel_q == bank_e'(b))),
         .waddr_i(md_waddr_i),
         .wdata_i(md_wdata_i),
         .re_i   (rd_ren_i),
         .raddr_i(rd_addr_i),
         .rdata_o(bankRdata[b])
      );
   end

   // Next-state for bank ownership, the per-LCU write counter and sticky errors;
   // finish and done can never target the same bank so both may apply at once
   always_comb begin
      wSel_d     = wSel_q;
      rSel_d     = rSel_q;
      rdSel_d    = rd_ren_i ? rSel_q : rdSel_q;
      bankFull_d = bankFull_q;
      wCnt_d     = wCntNext;
      lcuCnt_d   = lcuCnt_q;
      err_d      = err_q;

      if ((md_we_i || md_finish_i) && !wrReady) begin
         err_d[ERR_WR] = 1'b1;
      end
      if (rd_done_i && !rdValid) begin
         err_d[ERR_RD] = 1'b1;
      end

      if (finishOk) begin
         bankFull_d[wSel_q] = 1'b1;
         wSel_d             = bank_e'(~wSel_q);
         wCnt_d             = '0;
         lcuCnt_d           = lcuCnt_q + 1'b1;
         if (wCntNext != WCNT_W'(MODE_CNT)) begin
            err_d[ERR_CNT] = 1'b1;
         end
      end

      if (doneOk) begin
         bankFull_d[rSel_q] = 1'b0;
         rSel_d             = bank_e'(~rSel_q);
      end
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wSel_q     <= BANK0;
         rSel_q     <= BANK0;
         rdSel_q    <= BANK0;
         bankFull_q <= '0;
         wCnt_q     <= '0;
         lcuCnt_q   <= '0;
         err_q      <= '0;
      end else begin
         wSel_q     <= wSel_d;
         rSel_q     <= rSel_d;
         rdSel_q    <= rdSel_d;
         bankFull_q <= bankFull_d;
         wCnt_q     <= wCnt_d;
         lcuCnt_q   <= lcuCnt_d;
         err_q      <= err_d;
      end
   end

   assign wr_ready_o = wrReady;
   assign rd_valid_o = rdValid;
   assign rd_data_o  = bankRdata[rdSel_q];
   assign lcu_cnt_o  = lcuCnt_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_pre_i_mode_pingpong.sv
// Directed bench for the pre-intra mode ping-pong buffer.
module tb_pre_i_mode_pingpong;

   logic        clk;
   logic        rstn;
   logic        md_we_i;
   logic [6:0]  md_waddr_i;
   logic [5:0]  md_wdata_i;
   logic        md_finish_i;
   logic        wr_ready_o;
   logic        rd_valid_o;
   logic        rd_ren_i;
   logic [6:0]  rd_addr_i;
   logic [5:0]  rd_data_o;
   logic        rd_done_i;
   logic [15:0] lcu_cnt_o;
   logic [2:0]  err_o;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      string      name;
      logic       ren;
      logic [6:0] addr;
      logic [5:0] expData;
   } rdVec_t;

   rdVec_t rdTable [6];

   pre_i_mode_pingpong dut (
      .clk        (clk),
      .rstn       (rstn),
      .md_we_i    (md_we_i),
      .md_waddr_i (md_waddr_i),
      .md_wdata_i (md_wdata_i),
      .md_finish_i(md_finish_i),
      .wr_ready_o (wr_ready_o),
      .rd_valid_o (rd_valid_o),
      .rd_ren_i   (rd_ren_i),
      .rd_addr_i  (rd_addr_i),
      .rd_data_o  (rd_data_o),
      .rd_done_i  (rd_done_i),
      .lcu_cnt_o  (lcu_cnt_o),
      .err_o      (err_o)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Mode value written at address i for an LCU tagged with seed
   function automatic logic [5:0] modeVal(input int i, input int seed);
      return 6'(((i % 35) + seed) % 64);
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, clock it, and settle 1ns past the edge
   task automatic applyStimulus(input logic we, input int waddr, input int wdata,
                                input logic fin, input logic ren, input int raddr,
                                input logic done);
      md_we_i     = we;
      md_waddr_i  = 7'(waddr);
      md_wdata_i  = 6'(wdata);
      md_finish_i = fin;
      rd_ren_i    = ren;
      rd_addr_i   = 7'(raddr);
      rd_done_i   = done;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic writeLcu(input int n, input int seed);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, i, modeVal(i, seed), 1'b0, 1'b0, 0, 1'b0);
      end
   endtask

   task automatic readCheck(input string name, input int addr, input int expData);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, addr, 1'b0);
      checkOutput(name, rd_data_o, expData);
   endtask

   initial begin
      rdTable[0] = '{name: "t1 read40",  ren: 1'b1, addr: 7'd40, expData: 6'd5};
      rdTable[1] = '{name: "t1 hold",    ren: 1'b0, addr: 7'd3,  expData: 6'd5};
      rdTable[2] = '{name: "t1 read0",   ren: 1'b1, addr: 7'd0,  expData: 6'd0};
      rdTable[3] = '{name: "t1 read34",  ren: 1'b1, addr: 7'd34, expData: 6'd34};
      rdTable[4] = '{name: "t1 read35",  ren: 1'b1, addr: 7'd35, expData: 6'd0};
      rdTable[5] = '{name: "t1 read84",  ren: 1'b1, addr: 7'd84, expData: 6'd14};

      rstn = 1'b0;
      idle();
      idle();
      checkOutput("rst wr_ready", wr_ready_o, 1);
      checkOutput("rst rd_valid", rd_valid_o, 0);
      checkOutput("rst lcu_cnt", lcu_cnt_o, 0);
      checkOutput("rst err", err_o, 0);
      checkOutput("rst rd_data", rd_data_o, 0);
      rstn = 1'b1;

      // Test 1: full LCU into bank0, visible one cycle after finish
      writeLcu(85, 0);
      checkOutput("t1 rd_valid before finish", rd_valid_o, 0);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("t1 rd_valid", rd_valid_o, 1);
      checkOutput("t1 wr_ready", wr_ready_o, 1);
      checkOutput("t1 lcu_cnt", lcu_cnt_o, 1);
      checkOutput("t1 err", err_o, 0);
      for (int v = 0; v < 6; v++) begin
         applyStimulus(1'b0, 0, 0, 1'b0, rdTable[v].ren, rdTable[v].addr, 1'b0);
         checkOutput(rdTable[v].name, rd_data_o, rdTable[v].expData);
         checkOutput({rdTable[v].name, " valid"}, rd_valid_o, 1);
      end

      // Test 4: bank1 closes (last write in the finish cycle) while bank0 is released
      writeLcu(84, 10);
      applyStimulus(1'b1, 84, modeVal(84, 10), 1'b1, 1'b0, 0, 1'b1);
      checkOutput("t4 rd_valid", rd_valid_o, 1);
      checkOutput("t4 wr_ready", wr_ready_o, 1);
      checkOutput("t4 lcu_cnt", lcu_cnt_o, 2);
      checkOutput("t4 err", err_o, 0);

      // Test 2: refill bank0 so both banks are full, then a dropped write
      writeLcu(85, 20);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("t2 wr_ready", wr_ready_o, 0);
      checkOutput("t2 rd_valid", rd_valid_o, 1);
      checkOutput("t2 lcu_cnt", lcu_cnt_o, 3);
      applyStimulus(1'b1, 40, 63, 1'b0, 1'b0, 0, 1'b0);
      checkOutput("t2 err dropped write", err_o, 3'b001);
      readCheck("t2 bank1 addr40", 40, 15);

      // Test 3: release bank1 while reading it in the same cycle
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 40, 1'b1);
      checkOutput("t3 done-cycle read", rd_data_o, 15);
      checkOutput("t3 rd_valid", rd_valid_o, 1);
      checkOutput("t3 wr_ready", wr_ready_o, 1);

      // Test 5: short LCU into the freed bank1, writing starts the cycle ready rises
      writeLcu(84, 30);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("t5 err count", err_o, 3'b101);
      checkOutput("t5 lcu_cnt", lcu_cnt_o, 4);
      checkOutput("t5 wr_ready", wr_ready_o, 0);
      readCheck("t5 bank0 addr40", 40, 25);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      checkOutput("t5 short bank full", rd_valid_o, 1);
      checkOutput("t5 wr_ready after done", wr_ready_o, 1);
      readCheck("t5 bank1 addr40", 40, 35);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      checkOutput("t5 rd_valid empty", rd_valid_o, 0);
      checkOutput("t5 err before bad done", err_o, 3'b101);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
      checkOutput("t5 err bad done", err_o, 3'b111);

      // Test 6: reset in the middle of an LCU
      writeLcu(40, 0);
      rstn = 1'b0;
      idle();
      rstn = 1'b1;
      checkOutput("t6 wr_ready", wr_ready_o, 1);
      checkOutput("t6 rd_valid", rd_valid_o, 0);
      checkOutput("t6 err", err_o, 0);
      checkOutput("t6 lcu_cnt", lcu_cnt_o, 0);
      checkOutput("t6 rd_data", rd_data_o, 0);
      writeLcu(85, 0);
      applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
      checkOutput("t6 err after LCU", err_o, 0);
      checkOutput("t6 lcu_cnt after LCU", lcu_cnt_o, 1);
      checkOutput("t6 rd_valid after LCU", rd_valid_o, 1);
      readCheck("t6 read84", 84, 14);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
